// File: rtl/handshake_register.sv
// handshake_register: single-clock valid/ready pipeline register.
//
// It cuts every timing path between an upstream stream (AM) and a downstream
// stream (BM). All outputs come straight from flops. Words leave BM in the
// order they entered AM, and no word is dropped or duplicated.
//
// Parameters:
//   WIDTH : payload width in bits (>= 1)
//   BURST : "no"  -> single-entry register. Throughput is one word every two
//                    cycles, and ready does not depend on any input.
//           "yes" -> two-entry skid buffer (MAIN + SKID). Throughput is one
//                    word per cycle, and ready is registered.
//
// Ports:
//   iCLK       clock, rising edge
//   iRST       asynchronous active-low reset
//   iValid_AM  upstream valid
//   oReady_AM  upstream ready; 0 while in reset, 1 from the first edge after
//   iData_AM   upstream payload
//   oValid_BM  downstream valid
//   iReady_BM  downstream ready
//   oData_BM   downstream payload; holds the last emitted word while invalid
//   iClear     synchronous flush. This port exists only when REGISTER_CLEAR_EN
//              is defined. A clear wins over a simultaneous accept, and
//              oData_BM keeps its value.
//
// Optional macro: REGISTER_CLEAR_EN (adds iClear).
module handshake_register #(
  parameter int unsigned WIDTH = 8,
  parameter string       BURST = "no"
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid_AM,
  output logic             oReady_AM,
  input  logic [WIDTH-1:0] iData_AM,
  output logic             oValid_BM,
  input  logic             iReady_BM,
`ifdef REGISTER_CLEAR_EN
  input  logic             iClear,
`endif
  output logic [WIDTH-1:0] oData_BM
);

  logic clear;
`ifdef REGISTER_CLEAR_EN
  assign clear = iClear;
`else
  assign clear = 1'b0;
`endif

  if (WIDTH < 1) begin : g_bad_width
    $error("handshake_register: WIDTH must be >= 1");
  end

  if (BURST == "no") begin : g_single
    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
      state_d = state_q;
      data_d  = data_q;
      unique case (state_q)
        StEmpty: begin
          // ready_q is still 0 on the first edge after reset, so that edge
          // cannot accept a word.
          if (iValid_AM && ready_q) begin
            state_d = StFull;
            data_d  = iData_AM;
          end
        end
        StFull: begin
          if (iReady_BM) state_d = StEmpty;
        end
      endcase
      if (clear) begin
        state_d = StEmpty;
        data_d  = data_q;
      end
      ready_d = (state_d == StEmpty);
    end

    always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
        state_q <= StEmpty;
        ready_q <= 1'b0;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        ready_q <= ready_d;
        data_q  <= data_d;
      end
    end

    assign oReady_AM = ready_q;
    assign oValid_BM = (state_q == StFull);
    assign oData_BM  = data_q;

  end else if (BURST == "yes") begin : g_skid
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             ready_q, ready_d;
    logic             accept, emit;

    // ready_q mirrors !skid_valid_q once out of reset. An accept therefore
    // always finds SKID empty.
    assign accept = iValid_AM && ready_q;
    assign emit   = main_valid_q && iReady_BM;

    always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;

      if (emit) begin
        if (skid_valid_q) begin
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end

      if (accept) begin
        if (!main_valid_q || emit) begin
          main_valid_d = 1'b1;
          main_data_d  = iData_AM;
        end else begin
          skid_valid_d = 1'b1;
          skid_data_d  = iData_AM;
        end
      end

      if (clear) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
      end

      ready_d = !skid_valid_d;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
        main_valid_q <= 1'b0;
        main_data_q  <= '0;
        skid_valid_q <= 1'b0;
        skid_data_q  <= '0;
        ready_q      <= 1'b0;
      end else begin
        main_valid_q <= main_valid_d;
        main_data_q  <= main_data_d;
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
        ready_q      <= ready_d;
      end
    end

    assign oReady_AM = ready_q;
    assign oValid_BM = main_valid_q;
    assign oData_BM  = main_data_q;

  end else begin : g_bad_burst
    $error("handshake_register: BURST must be \"no\" or \"yes\"");
    assign oReady_AM = 1'b0;
    assign oValid_BM = 1'b0;
    assign oData_BM  = '0;
  end

endmodule

// File: tb/tb_handshake_register.sv
// Bench for handshake_register. Two instances are driven side by side:
// dut_n uses BURST="no" and dut_y uses BURST="yes". Each directed test pushes
// its hand-computed output words into a per-instance queue. A negedge monitor
// pops and compares a word whenever its instance presents valid with ready.
module tb_handshake_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       n_valid, n_ready_am, n_valid_bm, n_ready_bm;
  logic [7:0] n_data, n_data_bm;
  logic       y_valid, y_ready_am, y_valid_bm, y_ready_bm;
  logic [7:0] y_data, y_data_bm;
`ifdef REGISTER_CLEAR_EN
  logic       n_clr, y_clr;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] qn[$];
  logic [7:0] qy[$];

  handshake_register #(.WIDTH(8), .BURST("no")) dut_n (
    .iCLK      (clk),
    .iRST      (rst_n),
    .iValid_AM (n_valid),
    .oReady_AM (n_ready_am),
    .iData_AM  (n_data),
    .oValid_BM (n_valid_bm),
    .iReady_BM (n_ready_bm),
`ifdef REGISTER_CLEAR_EN
    .iClear    (n_clr),
`endif
    .oData_BM  (n_data_bm)
  );

  handshake_register #(.WIDTH(8), .BURST("yes")) dut_y (
    .iCLK      (clk),
    .iRST      (rst_n),
    .iValid_AM (y_valid),
    .oReady_AM (y_ready_am),
    .iData_AM  (y_data),
    .oValid_BM (y_valid_bm),
    .iReady_BM (y_ready_bm),
`ifdef REGISTER_CLEAR_EN
    .iClear    (y_clr),
`endif
    .oData_BM  (y_data_bm)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor. Inputs change only at posedge+1, so the values seen
  // at negedge are the ones the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (n_valid_bm && n_ready_bm) begin
        if (qn.size() == 0) chk("n_unexpected_emit", {24'd0, n_data_bm}, 32'hFFFF_FFFF);
        else chk("n_emit", {24'd0, n_data_bm}, {24'd0, qn.pop_front()});
      end
      if (y_valid_bm && y_ready_bm) begin
        if (qy.size() == 0) chk("y_unexpected_emit", {24'd0, y_data_bm}, 32'hFFFF_FFFF);
        else chk("y_emit", {24'd0, y_data_bm}, {24'd0, qy.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // BURST="yes" stream vectors, one entry per cycle.
  logic [7:0] y_drv [11] = '{8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h6, 8'h6, 8'h7, 8'h8, 8'h0};
  logic       y_rbm [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  logic       y_rdy [11] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
  logic       y_vld [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  logic [7:0] n_w4  [5]  = '{8'hC, 8'hD, 8'hD, 8'hE, 8'hE};

  initial begin
    rst_n = 1'b0;
    n_valid = 0; n_data = 8'hxx; n_ready_bm = 0;
    y_valid = 0; y_data = 8'hxx; y_ready_bm = 0;
`ifdef REGISTER_CLEAR_EN
    n_clr = 0; y_clr = 0;
`endif
    #2;
    chk("rst_n_valid", {31'd0, n_valid_bm}, 0);
    chk("rst_n_data",  {24'd0, n_data_bm}, 0);
    chk("rst_n_ready", {31'd0, n_ready_am}, 0);
    chk("rst_y_ready", {31'd0, y_ready_am}, 0);
    chk("rst_y_valid", {31'd0, y_valid_bm}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_n_ready", {31'd0, n_ready_am}, 1);
    chk("post_rst_y_ready", {31'd0, y_ready_am}, 1);

    // Test 1: single word with downstream stalled, then released.
    n_valid = 1; n_data = 8'hA; n_ready_bm = 0; qn.push_back(8'hA);
    tick();
    n_valid = 0; n_data = 8'hxx;
    chk("t1_valid", {31'd0, n_valid_bm}, 1);
    chk("t1_data",  {24'd0, n_data_bm}, 8'hA);
    chk("t1_ready", {31'd0, n_ready_am}, 0);
    n_ready_bm = 1;
    tick();
    n_ready_bm = 0;
    chk("t1_valid_after", {31'd0, n_valid_bm}, 0);
    chk("t1_ready_after", {31'd0, n_ready_am}, 1);
    chk("t1_data_hold",   {24'd0, n_data_bm}, 8'hA);

    // Test 2: four-cycle stall holds the word stable, then exactly one emit.
    n_valid = 1; n_data = 8'h7; qn.push_back(8'h7);
    tick();
    n_valid = 0; n_data = 8'hxx;
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", {31'd0, n_valid_bm}, 1);
      chk("t2_data",  {24'd0, n_data_bm}, 8'h7);
      chk("t2_ready", {31'd0, n_ready_am}, 0);
      tick();
    end
    n_ready_bm = 1;
    tick();
    n_ready_bm = 0;
    chk("t2_valid_after", {31'd0, n_valid_bm}, 0);
    chk("t2_ready_after", {31'd0, n_ready_am}, 1);

    // Test 3: a second word offered while full must not be taken.
    n_valid = 1; n_data = 8'hA; qn.push_back(8'hA);
    tick();
    n_data = 8'hB;
    chk("t3_ready_full", {31'd0, n_ready_am}, 0);
    tick();
    n_valid = 0; n_data = 8'hxx;
    chk("t3_valid", {31'd0, n_valid_bm}, 1);
    chk("t3_data",  {24'd0, n_data_bm}, 8'hA);
    n_ready_bm = 1;
    tick();
    n_ready_bm = 0;
    tick();
    chk("t3_no_b", {31'd0, n_valid_bm}, 0);
    chk("t3_data_hold", {24'd0, n_data_bm}, 8'hA);

    // Test 4: held-until-accepted stream shows alternating ready.
    qn.push_back(8'hC); qn.push_back(8'hD); qn.push_back(8'hE);
    n_ready_bm = 1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_ready_alt", {31'd0, n_ready_am}, (i % 2 == 0) ? 32'd1 : 32'd0);
      n_valid = 1; n_data = n_w4[i];
      tick();
    end
    n_valid = 0; n_data = 8'hxx;
    tick();
    tick();
    n_ready_bm = 0;
    chk("t4_drain", 32'(qn.size()), 0);

    // Test 5: BURST="yes" full-rate stream with a two-cycle downstream stall.
    for (int i = 1; i <= 8; i++) qy.push_back(8'(i));
    for (int i = 0; i < 11; i++) begin
      if (i < 10) chk("t5_ready", {31'd0, y_ready_am}, {31'd0, y_rdy[i]});
      chk("t5_valid", {31'd0, y_valid_bm}, {31'd0, y_vld[i]});
      if (i == 5 || i == 6) chk("t5_stall_data", {24'd0, y_data_bm}, 8'h4);
      y_ready_bm = y_rbm[i];
      y_valid = (i < 10);
      y_data = (i < 10) ? y_drv[i] : 8'hxx;
      tick();
    end
    y_valid = 0; y_data = 8'hxx;
    chk("t5_valid_end", {31'd0, y_valid_bm}, 0);
    chk("t5_data_hold", {24'd0, y_data_bm}, 8'h8);
    y_ready_bm = 0;
    chk("t5_drain", 32'(qy.size()), 0);

    // Test 6: asynchronous reset while full discards the word immediately.
    n_valid = 1; n_data = 8'h5; n_ready_bm = 0;
    tick();
    n_valid = 0; n_data = 8'hxx;
    chk("t6_full_valid", {31'd0, n_valid_bm}, 1);
    chk("t6_full_data",  {24'd0, n_data_bm}, 8'h5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, n_valid_bm}, 0);
    chk("t6_rst_data",  {24'd0, n_data_bm}, 0);
    chk("t6_rst_ready", {31'd0, n_ready_am}, 0);
    chk("t6_rst_y_data", {24'd0, y_data_bm}, 0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t6_ready_back", {31'd0, n_ready_am}, 1);

`ifdef REGISTER_CLEAR_EN
    // Test 7: clear while full, and clear beating a simultaneous accept.
    n_valid = 1; n_data = 8'h5;
    tick();
    n_valid = 0; n_data = 8'hxx; n_clr = 1;
    tick();
    n_clr = 0;
    chk("t7_clr_valid", {31'd0, n_valid_bm}, 0);
    chk("t7_clr_ready", {31'd0, n_ready_am}, 1);
    chk("t7_clr_data",  {24'd0, n_data_bm}, 8'h5);
    y_valid = 1; y_data = 8'h33; y_clr = 1;
    tick();
    y_valid = 0; y_data = 8'hxx; y_clr = 0;
    chk("t7_y_clr_valid", {31'd0, y_valid_bm}, 0);
    chk("t7_y_clr_ready", {31'd0, y_ready_am}, 1);
`endif

    tick();
    chk("final_n_drain", 32'(qn.size()), 0);
    chk("final_y_drain", 32'(qy.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_register.md
Name: handshake_register

Overview:
- Single-clock valid/ready pipeline register that cuts timing paths between an upstream (AM) and a downstream (BM) stream interface.
- Data is accepted from AM and presented on BM in order, never dropped or duplicated.
- BURST selects the implementation:
  - "no": single-entry register, half throughput, no combinational ready path.
  - "yes": two-entry skid buffer, full throughput, registered ready.

Parameters:
- WIDTH, 8, payload width in bits (must be >= 1).
- BURST, "no", "no" = single-entry half-rate register; "yes" = two-entry full-rate skid buffer; any other value is a configuration error (elaboration-time $error).

Ports:
- iCLK  input  1  clock; all state updates on the rising edge.
- iRST  input  1  asynchronous active-low reset.
- iValid_AM  input  1  upstream data valid.
- oReady_AM  output  1  register can accept data this cycle.
- iData_AM  input  WIDTH  upstream payload.
- oValid_BM  output  1  downstream data valid.
- iReady_BM  input  1  downstream accepts data this cycle.
- oData_BM  output  WIDTH  downstream payload.
- iClear  input  1  synchronous flush; present only with REGISTER_CLEAR_EN.

Behaviour:
- Transfers:
  - Accept on AM when iValid_AM & oReady_AM at a rising edge.
  - Emit on BM when oValid_BM & iReady_BM at a rising edge.
- Reset (iRST=0, asynchronous):
  - All entries empty; oValid_BM=0; oData_BM=0; oReady_AM=0.
  - After iRST rises, oReady_AM=1 from the first clock edge on.
  - Reset mid-transfer discards stored data.
- All outputs are driven directly from flops. No combinational path from any input to any output.
- Handshake rules:
  - oValid_BM and oData_BM stay stable while oValid_BM=1 and iReady_BM=0.
  - iData_AM is ignored when no transfer occurs.
  - iReady_BM may toggle freely.
  - X on iData_AM without iValid_AM never reaches oData_BM.
- BURST="no": states EMPTY and FULL.
  - EMPTY: oReady_AM=1, oValid_BM=0. On accept, latch iData_AM and go to FULL.
  - FULL: oReady_AM=0, oValid_BM=1, oData_BM=latched value. On emit, go to EMPTY.
  - Accept and emit never happen in the same cycle.
  - Latency: data accepted at edge N is valid on BM after edge N.
  - Maximum throughput is one word every 2 cycles.
- BURST="yes": entries MAIN (drives BM) and SKID.
  - oReady_AM = SKID empty (registered).
  - Accept with MAIN empty, or with MAIN emitting this cycle: data goes to MAIN.
  - Accept with MAIN full and not emitting: data goes to SKID.
  - Emit with SKID full: SKID moves to MAIN and SKID empties.
  - Sustains one word per cycle with iReady_BM=1 and iValid_AM=1.
  - Latency is 1 cycle.
  - With both entries full, oReady_AM=0 until an emit.
- Order is always FIFO. No data loss on simultaneous accept and emit.
- oData_BM holds the last emitted value when oValid_BM=0 (0 after reset).

Optional Feature:
- Macro: REGISTER_CLEAR_EN.
- When defined:
  - Adds port iClear.
  - iClear=1 at a rising edge empties all entries; oValid_BM=0 next cycle; oReady_AM=1.
  - Clear wins over a simultaneous accept: the incoming word is dropped.
  - oData_BM is unchanged.
- When undefined: no iClear port; behaviour is exactly as above.

Test Plan:
- BURST="no", reset, then iValid_AM=1/iData_AM=0xA with iReady_BM=0 for 1 cycle:
  - oValid_BM=1 and oData_BM=0xA next cycle; oReady_AM=0.
  - Raise iReady_BM: one emit of 0xA, then oValid_BM=0 and oReady_AM=1.
- BURST="no", accept 0x7 then stall iReady_BM=0 for 4 cycles:
  - oData_BM stays 0x7 with oValid_BM=1 and oReady_AM=0 throughout.
  - iReady_BM=1: emitted exactly once.
- BURST="no", iValid_AM=1 with 0xA then 0xB on consecutive cycles, iReady_BM=0:
  - 0xA accepted; 0xB is not accepted (oReady_AM=0).
  - Output stays 0xA.
- BURST="no", iReady_BM=1, iValid_AM=1 with data held until accepted, words 0xC, 0xD, 0xE:
  - Emitted in order 0xC, 0xD, 0xE.
  - oReady_AM alternates 1/0 (one word per 2 cycles).
- BURST="yes", continuous valid 0x1..0x8 with iReady_BM=1:
  - One word emitted per cycle, in order.
  - Drop iReady_BM for 2 cycles mid-stream: oReady_AM falls after SKID fills, no loss, order preserved.
- Assert iRST=0 while FULL holding 0x5:
  - oValid_BM=0 and oData_BM=0 immediately (asynchronous).
  - With REGISTER_CLEAR_EN, iClear=1 while FULL: oValid_BM=0 on the next cycle.
